// File: rtl/jump_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// jump_pc_unit_pkg
// Shared definitions for the Hack next-PC stage.
//   HACK_WIDTH  : datapath width (fixed at 16)
//   jump_t      : C-instruction jump field encodings {j1,j2,j3}
//   jump_cond() : evaluates the jump condition from the jump field and flags
// ---------------------------------------------------------------------------
package jump_pc_unit_pkg;

   localparam int HACK_WIDTH = 16;

   typedef enum logic [2:0] {
      JNULL = 3'b000,
      JGT   = 3'b001,
      JEQ   = 3'b010,
      JGE   = 3'b011,
      JLT   = 3'b100,
      JNE   = 3'b101,
      JLE   = 3'b110,
      JMP   = 3'b111
   } jump_t;

   // j1 selects "negative", j2 "zero", j3 "positive"; any selected match jumps.
   function automatic logic jump_cond(input logic [2:0] jbits,
                                      input logic       zr,
                                      input logic       ng);
      logic pos;
      pos = ~zr & ~ng;
      return (jbits[2] & ng) | (jbits[1] & zr) | (jbits[0] & pos);
   endfunction

endpackage

// File: rtl/zero_detect16.sv
// ---------------------------------------------------------------------------
// zero_detect16
// Zero detect for a 16-bit word, built as two or8way reductions (one per
// byte), an or_gate joining them and an inverter.
// Ports:
//   data : input  [15:0]  word under test
//   zr   : output         1 when data == 0
// ---------------------------------------------------------------------------
module zero_detect16 (
   input  logic [15:0] data,
   output logic        zr
);

   logic [1:0] half_any;
   logic       any_set;

   // One or8way per byte lane.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_or8way
         assign half_any[gi] = |data[gi*8 +: 8];
      end
   endgenerate

   assign any_set = half_any[0] | half_any[1];   // or_gate
   assign zr      = ~any_set;                    // inverter

endmodule

// File: rtl/jump_pc_unit.sv
// ---------------------------------------------------------------------------
// jump_pc_unit
// Next-PC stage of the Hack CPU. Derives zr/ng from the ALU result, decodes
// the C-instruction jump field and holds the program counter.
// Optional feature macro: JUMP_PC_PERF_EN (adds a saturating taken-jump
// counter with a synchronous clear).
// Ports:
//   clk        : input        rising-edge clock
//   rst_n      : input        asynchronous active-low reset
//   en         : input        advance enable; 0 holds every register
//   is_c_instr : input        current instruction is a C-instruction
//   jump_bits  : input  [2:0] {j1,j2,j3}
//   alu_out    : input  [15:0] ALU result of the current instruction
//   a_reg      : input  [15:0] jump target
//   pc_out     : output [15:0] registered program counter
//   jump_taken : output       last advancing cycle loaded a_reg
//   zr_q, ng_q : output       flags of the last C-instruction
//   perf_clr   : input        (JUMP_PC_PERF_EN) synchronous counter clear
//   jump_count : output [15:0] (JUMP_PC_PERF_EN) saturating taken-jump count
// ---------------------------------------------------------------------------
module jump_pc_unit
   import jump_pc_unit_pkg::*;
#(
   parameter int               WIDTH        = HACK_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             is_c_instr,
   input  logic [2:0]       jump_bits,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [WIDTH-1:0] a_reg,
   output logic [WIDTH-1:0] pc_out,
   output logic             jump_taken,
   output logic             zr_q,
   output logic             ng_q
`ifdef JUMP_PC_PERF_EN
   ,
   input  logic             perf_clr,
   output logic [15:0]      jump_count
`endif
);

   logic             zr;
   logic             ng;
   logic             take;
   logic [WIDTH-1:0] pc_reg;
   logic [WIDTH-1:0] pc_next;
   logic             jump_taken_reg;
   logic             zr_reg;
   logic             ng_reg;

   zero_detect16 u_zero_detect (
      .data (alu_out),
      .zr   (zr)
   );

   assign ng   = alu_out[WIDTH-1];
   // A-instructions never jump; en=0 (HOLD) gates the decision entirely.
   assign take = en & is_c_instr & jump_cond(jump_bits, zr, ng);

   always_comb begin
      pc_next = pc_reg + WIDTH'(1);   // wraps modulo 2^WIDTH
      if (take) begin
         pc_next = a_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg         <= RESET_VECTOR;
         jump_taken_reg <= 1'b0;
         zr_reg         <= 1'b0;
         ng_reg         <= 1'b0;
      end else if (en) begin
         pc_reg         <= pc_next;
         jump_taken_reg <= take;
         if (is_c_instr) begin
            zr_reg <= zr;
            ng_reg <= ng;
         end
      end
   end

   assign pc_out     = pc_reg;
   assign jump_taken = jump_taken_reg;
   assign zr_q       = zr_reg;
   assign ng_q       = ng_reg;

`ifdef JUMP_PC_PERF_EN
   logic [15:0] jump_count_reg;

   // Clear beats a same-cycle taken jump; the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jump_count_reg <= '0;
      end else if (perf_clr) begin
         jump_count_reg <= '0;
      end else if (take && (jump_count_reg != 16'hFFFF)) begin
         jump_count_reg <= jump_count_reg + 16'd1;
      end
   end

   assign jump_count = jump_count_reg;
`endif

endmodule

// File: tb/tb_jump_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_jump_pc_unit
// Directed bench for jump_pc_unit. The driver applies one vector per clock
// on the falling edge and queues the hand-derived response; the monitor pops
// one entry after each rising edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_jump_pc_unit;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        is_c_instr;
   logic [2:0]  jump_bits;
   logic [15:0] alu_out;
   logic [15:0] a_reg;
   logic [15:0] pc_out;
   logic        jump_taken;
   logic        zr_q;
   logic        ng_q;
   logic        perf_clr;
   logic [15:0] jump_count;

   jump_pc_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .is_c_instr (is_c_instr),
      .jump_bits  (jump_bits),
      .alu_out    (alu_out),
      .a_reg      (a_reg),
      .pc_out     (pc_out),
      .jump_taken (jump_taken),
      .zr_q       (zr_q),
      .ng_q       (ng_q)
`ifdef JUMP_PC_PERF_EN
      ,
      .perf_clr   (perf_clr),
      .jump_count (jump_count)
`endif
   );

`ifndef JUMP_PC_PERF_EN
   assign jump_count = 16'h0000;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] pc;
      logic        jt;
      logic        zr;
      logic        ng;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];

   int n_vec  = 0;
   int n_miss = 0;

   // Expected architectural state, advanced by the driver.
   logic [15:0] exp_pc  = 16'h0000;
   logic        exp_jt  = 1'b0;
   logic        exp_zr  = 1'b0;
   logic        exp_ng  = 1'b0;
   logic [15:0] exp_cnt = 16'h0000;

   // Taken masks indexed by jump_bits, worked out by hand per flag case.
   localparam logic [7:0] MASK_ZERO = 8'b1100_1100;   // JEQ JGE JLE JMP
   localparam logic [7:0] MASK_POS  = 8'b1010_1010;   // JGT JGE JNE JMP
   localparam logic [7:0] MASK_NEG  = 8'b1111_0000;   // JLT JNE JLE JMP

   function automatic void compare(input exp_t e);
      logic bad;
      bad = (pc_out !== e.pc) || (jump_taken !== e.jt) ||
            (zr_q !== e.zr) || (ng_q !== e.ng);
`ifdef JUMP_PC_PERF_EN
      bad = bad || (jump_count !== e.cnt);
`endif
      n_vec++;
      if (bad) begin
         n_miss++;
         $display("FAIL %s: got pc=%h jt=%b zr=%b ng=%b cnt=%h, expected pc=%h jt=%b zr=%b ng=%b cnt=%h",
                  e.name, pc_out, jump_taken, zr_q, ng_q, jump_count,
                  e.pc, e.jt, e.zr, e.ng, e.cnt);
      end else begin
         $display("vec %s: pc=%h jt=%b zr=%b ng=%b cnt=%h ok",
                  e.name, pc_out, jump_taken, zr_q, ng_q, jump_count);
      end
   endfunction

   // tk is the hand-derived jump decision for this vector.
   task automatic step(input logic e, input logic c, input logic [2:0] jb,
                       input logic [15:0] alu, input logic [15:0] a,
                       input logic tk, input logic clr, input string nm);
      exp_t x;
      @(negedge clk);
      en = e; is_c_instr = c; jump_bits = jb;
      alu_out = alu; a_reg = a; perf_clr = clr;
      if (e) begin
         exp_pc = tk ? a : exp_pc + 16'd1;
         exp_jt = tk;
         if (c) begin
            exp_zr = (alu == 16'h0000);
            exp_ng = alu[15];
         end
      end
      if (clr) exp_cnt = 16'h0000;
      else if (tk && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      x.name = nm; x.pc = exp_pc; x.jt = exp_jt;
      x.zr = exp_zr; x.ng = exp_ng; x.cnt = exp_cnt;
      q.push_back(x);
   endtask

   task automatic check_now(input string nm);
      exp_t x;
      x.name = nm; x.pc = exp_pc; x.jt = exp_jt;
      x.zr = exp_zr; x.ng = exp_ng; x.cnt = exp_cnt;
      compare(x);
   endtask

   // Monitor: one response per rising edge while work is queued.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) compare(q.pop_front());
      end
   end

   initial begin
      logic [15:0] alus [3];
      logic [7:0]  masks [3];
      alus[0] = 16'h0000; masks[0] = MASK_ZERO;
      alus[1] = 16'h0005; masks[1] = MASK_POS;
      alus[2] = 16'hFFFB; masks[2] = MASK_NEG;

      rst_n = 1'b0; en = 1'b0; is_c_instr = 1'b0; jump_bits = 3'b000;
      alu_out = 16'h0000; a_reg = 16'h0000; perf_clr = 1'b0;
      #2;
      check_now("reset_initial");
      @(negedge clk);
      rst_n = 1'b1;

      // Mid-run asynchronous reset from pc=0123, jt=1, ng=1.
      step(1'b1, 1'b1, 3'b111, 16'hFFFB, 16'h0123, 1'b1, 1'b0, "jmp_0123");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      exp_pc = 16'h0000; exp_jt = 1'b0; exp_zr = 1'b0;
      exp_ng = 1'b0; exp_cnt = 16'h0000;
      check_now("reset_async_midcycle");
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Increment and wrap; the A-instruction carries JMP with alu=0.
      step(1'b1, 1'b1, 3'b111, 16'h0005, 16'hFFFE, 1'b1, 1'b0, "preload_fffe");
      step(1'b1, 1'b0, 3'b111, 16'h0000, 16'h0040, 1'b0, 1'b0, "a_instr_ffff");
      step(1'b1, 1'b0, 3'b111, 16'h0000, 16'h0040, 1'b0, 1'b0, "wrap_0000");

      // Condition sweep.
      for (int ai = 0; ai < 3; ai++) begin
         for (int j = 0; j < 8; j++) begin
            logic [7:0] m;
            m = masks[ai];
            step(1'b1, 1'b1, 3'(j), alus[ai], 16'h0040, m[j], 1'b0,
                 $sformatf("sweep_alu%h_j%0d", alus[ai], j));
         end
      end

      // A-instruction after a negative C-instruction: flags must stay zr=0 ng=1.
      step(1'b1, 1'b0, 3'b111, 16'h0000, 16'h0300, 1'b0, 1'b0, "a_instr_keep_flags");

      // Hold with JMP pending, then the jump lands.
      for (int h = 0; h < 3; h++)
         step(1'b0, 1'b1, 3'b111, 16'h0000, 16'h0200, 1'b0, 1'b0, $sformatf("hold_%0d", h));
      step(1'b1, 1'b1, 3'b111, 16'h0000, 16'h0200, 1'b1, 1'b0, "hold_release_jmp");

`ifdef JUMP_PC_PERF_EN
      step(1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 1'b1, "perf_clear");
      for (int k = 0; k < 5; k++)
         step(1'b1, 1'b1, 3'b111, 16'h0005, 16'h0010 + 16'(k), 1'b1, 1'b0,
              $sformatf("perf_jump_%0d", k));
      step(1'b1, 1'b1, 3'b111, 16'h0005, 16'h0020, 1'b1, 1'b1, "perf_clr_wins");
      @(negedge clk);
      en = 1'b0;
      perf_clr = 1'b0;
      force dut.jump_count_reg = 16'hFFFF;
      #1;
      release dut.jump_count_reg;
      exp_cnt = 16'hFFFF;
      step(1'b1, 1'b1, 3'b111, 16'h0005, 16'h0030, 1'b1, 1'b0, "perf_saturate");
`endif

      @(negedge clk);
      en = 1'b0;
      for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
      #2;
      if (q.size() > 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL drain: %0d responses still pending, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/jump_pc_unit.md
Name: jump_pc_unit

Overview:
- Next-PC stage of the Hack CPU; consumes the 16-bit ALU result and the C-instruction jump field.
- Derives zr/ng flags (zero detect built from or8way), evaluates the jump condition, and holds the program-counter register.
- Output pc_out drives the instruction-ROM address. Single clock domain.

Parameters:
- RESET_VECTOR, 16'h0000, value loaded into the PC on reset.
- WIDTH, 16, datapath width; fixed at 16 and not overridable in practice (zero detect is hard-wired to two 8-bit halves).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; when 0 every register holds.
- is_c_instr  input  1  current instruction is a C-instruction (instr[15]).
- jump_bits  input  3  {j1,j2,j3} = instr[2:0].
- alu_out  input  16  ALU result for the current instruction.
- a_reg  input  16  A register, the jump target.
- pc_out  output  16  registered program counter.
- jump_taken  output  1  registered; 1 if the last advancing cycle loaded a_reg.
- zr_q  output  1  registered zero flag of the last C-instruction.
- ng_q  output  1  registered negative flag of the last C-instruction.

Behaviour:
- Reset is asynchronous and active-low: when rst_n=0, immediately set pc_out=RESET_VECTOR, jump_taken=0, zr_q=0, ng_q=0. Reset has priority over everything. Release is synchronous-safe, so the first advance happens on the first rising edge with rst_n=1 and en=1.
- Combinational flags:
  - zr = ~(or8way(alu_out[7:0]) | or8way(alu_out[15:8])).
  - ng = alu_out[15].
  - pos = ~zr & ~ng.
- cond = (j1&ng) | (j2&zr) | (j3&pos).
  - 000 never jumps; 111 always jumps (including when alu_out=0).
- take = en & is_c_instr & cond.
- Register update on the rising edge, in priority order:
  - en=0: pc_out, jump_taken, zr_q and ng_q all hold.
  - take=1: pc_out <= a_reg; jump_taken <= 1.
  - en=1, take=0: pc_out <= pc_out + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000, no flag); jump_taken <= 0.
- Flag latch: zr_q/ng_q <= zr/ng only when en & is_c_instr. A-instructions leave them unchanged.
- A-instructions (is_c_instr=0) never jump, whatever the jump_bits and alu_out values.
- Latency: a jump decision made in cycle N is visible on pc_out in cycle N+1. There are no bubbles and no stall beyond en.
- Jump to self (a_reg == pc_out) is legal: PC stays constant while the condition holds.
- Reset asserted mid-run: asynchronous clear; any in-flight jump decision is discarded.
- Internal state is two-state: RUN (en=1) and HOLD (en=0). HOLD is purely a gating condition with no extra storage.

Optional Feature:
- Macro: JUMP_PC_PERF_EN.
- When defined, adds:
  - Output port jump_count[15:0]: a saturating counter of taken jumps. It increments on every edge with take=1, stops at 16'hFFFF, and resets to 0 on rst_n=0.
  - Input port perf_clr: synchronous clear to 0. If clear and a taken jump occur in the same cycle, the clear wins.
- When undefined, neither port nor any counter logic exists, and behaviour is otherwise identical.

Decomposition:
- Shared header basics/hack_defs.vh, guarded with ifndef, holds:
  - Jump encodings: JNULL=000, JGT=001, JEQ=010, JGE=011, JLT=100, JNE=101, JLE=110, JMP=111.
  - Constant HACK_WIDTH=16.
- One natural sub-module, zero_detect16: two or8way instances plus an or_gate and an inverter, producing zr.
- Jump decode and the PC register stay in jump_pc_unit.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-cycle with pc_out=16'h0123 -> pc_out=0000, jump_taken=0, zr_q=ng_q=0 immediately, without waiting for a clock edge.
- Increment and wrap: preload pc_out=16'hFFFE via JMP, then en=1, is_c_instr=0 for 2 cycles -> pc_out reads FFFF then 0000, jump_taken=0.
- Condition sweep: alu_out in {16'h0000, 16'h0005, 16'hFFFB} × all 8 jump_bits, with a_reg=16'h0040 and is_c_instr=1 -> pc_out=0040 exactly when the encoding matches. For example, JGE with 0000 jumps, JGT with 0000 does not, and JNE with FFFB jumps.
- A-instruction ignores jump: is_c_instr=0, jump_bits=111, alu_out=0 -> pc_out increments; zr_q/ng_q unchanged.
- Hold: en=0 for 3 cycles with JMP asserted -> pc_out, jump_taken and flags frozen; on the first cycle after en returns to 1, the jump lands.
- With JUMP_PC_PERF_EN defined: 5 taken jumps, then perf_clr asserted together with a taken jump -> jump_count reads 5, then 0. Forcing the counter to FFFF and taking another jump -> it stays at FFFF.
